// File: rtl/tracker_pkg.sv
// Shared types and defaults for the multi-region colour tracker.
// Optional feature macro: TRACKER_DEBOUNCE_EN (per-region flag debounce).
package tracker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int unsigned DEF_NUM_REGIONS = 4;
  localparam int unsigned DEF_FRAME_W     = 640;
  localparam int unsigned DEF_FRAME_H     = 480;
  localparam int unsigned DEF_CNT_W       = 17;
  localparam int unsigned DEF_DEBOUNCE    = 3;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned width_for(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/region_counter.sv
// One region's saturating hit counter, captured frame count and detect flag.
// With TRACKER_DEBOUNCE_EN defined the flag only changes after DEBOUNCE
// consecutive frames disagreeing with it; otherwise it follows the raw detect.
module region_counter
  import tracker_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W
`ifdef TRACKER_DEBOUNCE_EN
  ,
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             hit,
  input  logic             capture,
  input  logic             update,
  input  logic [CNT_W-1:0] threshold,
  output logic [CNT_W-1:0] count,
  output logic             flag
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flag_q, flag_d;
  logic             raw_detect;

  // Next counter value: restart on frame start, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d    = '0;
      cnt_d[0] = hit;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    count_d = capture ? cnt_q : count_q;
  end

  // Running counter and the completed-frame snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  assign raw_detect = (count_q >= threshold);

`ifdef TRACKER_DEBOUNCE_EN
  localparam int unsigned RUN_W = width_for(DEBOUNCE + 1);

  logic [RUN_W-1:0] run_q, run_d;

  // Count frames whose raw detect disagrees with the flag; flip when the run completes.
  always_comb begin
    flag_d = flag_q;
    run_d  = run_q;
    if (update) begin
      if (raw_detect == flag_q) begin
        run_d = '0;
      end else if ((32'(run_q) + 32'd1) >= DEBOUNCE) begin
        flag_d = raw_detect;
        run_d  = '0;
      end else begin
        run_d = run_q + RUN_W'(1);
      end
    end
  end

  // Flag and debounce run state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      run_q  <= '0;
    end else begin
      flag_q <= flag_d;
      run_q  <= run_d;
    end
  end
`else
  // Flag follows the raw detect of the last completed frame.
  always_comb begin
    flag_d = update ? raw_detect : flag_q;
  end

  // Flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end
`endif

  assign count = count_q;
  assign flag  = flag_q;

endmodule

// File: rtl/multi_region_tracker.sv
// Counts target-colour hits in NUM_REGIONS vertical strips per frame and
// flags strips whose count reaches a threshold.
// Optional feature macro: TRACKER_DEBOUNCE_EN (per-region flag debounce).
module multi_region_tracker
  import tracker_pkg::*;
#(
  parameter int unsigned NUM_REGIONS = DEF_NUM_REGIONS,
  parameter int unsigned FRAME_W     = DEF_FRAME_W,
  parameter int unsigned FRAME_H     = DEF_FRAME_H,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DEBOUNCE    = DEF_DEBOUNCE
) (
  input  logic                         CLOCK_24,
  input  logic                         rst_n,
  input  logic                         frame_start,
  input  logic                         pix_valid,
  input  logic                         pix_hit,
  input  logic [9:0]                   x,
  input  logic [9:0]                   y,
  input  logic [CNT_W-1:0]             threshold,
  output logic [NUM_REGIONS-1:0]       region_flags,
  output logic [NUM_REGIONS*CNT_W-1:0] region_count,
  output logic                         frame_done
);

  localparam int unsigned REGION_W   = FRAME_W / NUM_REGIONS;
  localparam logic [10:0] ACTIVE_W_L = 11'(NUM_REGIONS * REGION_W);
  localparam logic [10:0] FRAME_H_L  = 11'(FRAME_H);
  localparam logic [9:0]  REGION_W_L = 10'(REGION_W);

  state_t           state_q, state_d;
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic             capture, update;
  logic             pix_ok;
  logic [9:0]       region_idx;
  logic [NUM_REGIONS-1:0] hit_vec;

  // Qualify the pixel and steer it to exactly one region.
  always_comb begin
    pix_ok     = pix_valid && pix_hit && ({1'b0, x} < ACTIVE_W_L) && ({1'b0, y} < FRAME_H_L);
    region_idx = x / REGION_W_L;
    hit_vec    = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      hit_vec[i] = pix_ok && (region_idx == 10'(i));
    end
  end

  // Frame sequencing: next state, snapshot/update strobes, threshold capture.
  always_comb begin
    state_d      = state_q;
    capture      = (state_q == ACCUM) && frame_start;
    update       = (state_q == LATCH);
    frame_done_d = update;
    thr_d        = capture ? threshold : thr_q;
    unique case (state_q)
      IDLE:    if (frame_start) state_d = ACCUM;
      ACCUM:   if (frame_start) state_d = LATCH;
      LATCH:   state_d = ACCUM;
      default: state_d = IDLE;
    endcase
  end

  // FSM state with its registered outputs.
  always_ff @(posedge CLOCK_24 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      frame_done_q <= 1'b0;
      thr_q        <= '0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= frame_done_d;
      thr_q        <= thr_d;
    end
  end

  assign frame_done = frame_done_q;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    region_counter #(
      .CNT_W    (CNT_W)
`ifdef TRACKER_DEBOUNCE_EN
      ,
      .DEBOUNCE (DEBOUNCE)
`endif
    ) u_region (
      .clk       (CLOCK_24),
      .rst_n     (rst_n),
      .clear     (frame_start),
      .hit       (hit_vec[g]),
      .capture   (capture),
      .update    (update),
      .threshold (thr_q),
      .count     (region_count[g*CNT_W +: CNT_W]),
      .flag      (region_flags[g])
    );
  end

`ifndef TRACKER_DEBOUNCE_EN
  // DEBOUNCE has no effect in this build; it is still accepted for drop-in use.
  if (DEBOUNCE == 0) begin : g_debounce_ignored
  end
`endif

endmodule

// File: tb/tb_multi_region_tracker.sv
// Directed self-checking bench for multi_region_tracker.
module tb_multi_region_tracker;

  logic        CLOCK_24;
  logic        rst_n;
  logic        frame_start;
  logic        pix_valid;
  logic        pix_hit;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [16:0] threshold;
  logic [11:0] thr12;

  logic [3:0]   flags0;
  logic [67:0]  rc0;
  logic         fd0;
  logic [3:0]   flags12;
  logic [47:0]  rc12;
  logic         fd12;
  logic [7:0]   flags8;
  logic [135:0] rc8;
  logic         fd8;

  int n_checks = 0;
  int n_fail   = 0;

  assign thr12 = threshold[11:0];

  multi_region_tracker #(.NUM_REGIONS(4), .CNT_W(17), .DEBOUNCE(1)) dut0 (
    .CLOCK_24(CLOCK_24), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_hit(pix_hit), .x(x), .y(y), .threshold(threshold),
    .region_flags(flags0), .region_count(rc0), .frame_done(fd0));

  multi_region_tracker #(.NUM_REGIONS(4), .CNT_W(12), .DEBOUNCE(1)) dut12 (
    .CLOCK_24(CLOCK_24), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_hit(pix_hit), .x(x), .y(y), .threshold(thr12),
    .region_flags(flags12), .region_count(rc12), .frame_done(fd12));

  multi_region_tracker #(.NUM_REGIONS(8), .CNT_W(17), .DEBOUNCE(3)) dut8 (
    .CLOCK_24(CLOCK_24), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_hit(pix_hit), .x(x), .y(y), .threshold(threshold),
    .region_flags(flags8), .region_count(rc8), .frame_done(fd8));

  initial begin
    CLOCK_24 = 1'b0;
    forever #5 CLOCK_24 = ~CLOCK_24;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLOCK_24);
    #1;
  endtask

  task automatic send_hits(input logic [9:0] hx, input logic [9:0] hy, input int n,
                           input logic v, input logic h);
    x = hx; y = hy; pix_valid = v; pix_hit = h;
    repeat (n) tick();
    pix_valid = 1'b0; pix_hit = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (fd0 !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %0d expected 0", fd0); end
    n_checks++; if (flags0 !== 4'h0) begin n_fail++; $display("FAIL reset_flags: got %h expected 0", flags0); end
    n_checks++; if (rc0 !== 68'h0) begin n_fail++; $display("FAIL reset_count: got %h expected 0", rc0); end
    n_checks++; if (flags8 !== 8'h0) begin n_fail++; $display("FAIL reset_flags8: got %h expected 0", flags8); end
    rst_n = 1'b1;
    tick();
    send_hits(10'd10, 10'd5, 30, 1'b1, 1'b1);
    pulse_fs();
    n_checks++; if (rc0 !== 68'h0) begin n_fail++; $display("FAIL partial_discard_count: got %h expected 0", rc0); end
    n_checks++; if (fd0 !== 1'b0) begin n_fail++; $display("FAIL first_fs_fd_a: got %0d expected 0", fd0); end
    tick();
    n_checks++; if (fd0 !== 1'b0) begin n_fail++; $display("FAIL first_fs_fd_b: got %0d expected 0", fd0); end
    tick();
  endtask

  task automatic test_basic();
    threshold = 17'd100;
    send_hits(10'd10, 10'd5, 150, 1'b1, 1'b1);
    pulse_fs();
    for (int i = 0; i < 4; i++) begin
      int exp_c;
      exp_c = (i == 0) ? 150 : 0;
      n_checks++; if (rc0[i*17 +: 17] !== 17'(exp_c)) begin n_fail++; $display("FAIL basic_count[%0d]: got %0d expected %0d", i, rc0[i*17 +: 17], exp_c); end
    end
    n_checks++; if (fd0 !== 1'b0) begin n_fail++; $display("FAIL basic_fd_early: got %0d expected 0", fd0); end
    tick();
    n_checks++; if (flags0 !== 4'b0001) begin n_fail++; $display("FAIL basic_flags: got %b expected 0001", flags0); end
    n_checks++; if (fd0 !== 1'b1) begin n_fail++; $display("FAIL basic_fd: got %0d expected 1", fd0); end
    tick();
    n_checks++; if (fd0 !== 1'b0) begin n_fail++; $display("FAIL basic_fd_once: got %0d expected 0", fd0); end
  endtask

  task automatic test_boundary();
    int exp_c [4];
    exp_c = '{4, 5, 0, 2};
    threshold = 17'd4;
    send_hits(10'd159, 10'd0, 3, 1'b1, 1'b1);
    send_hits(10'd160, 10'd0, 5, 1'b1, 1'b1);
    send_hits(10'd639, 10'd0, 2, 1'b1, 1'b1);
    send_hits(10'd640, 10'd0, 4, 1'b1, 1'b1);
    send_hits(10'd700, 10'd0, 7, 1'b1, 1'b1);
    send_hits(10'd1023, 10'd0, 2, 1'b1, 1'b1);
    send_hits(10'd10, 10'd480, 9, 1'b1, 1'b1);
    send_hits(10'd10, 10'd479, 1, 1'b1, 1'b1);
    send_hits(10'd10, 10'd0, 4, 1'b0, 1'b1);
    send_hits(10'd10, 10'd0, 2, 1'b1, 1'b0);
    pulse_fs();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (rc0[i*17 +: 17] !== 17'(exp_c[i])) begin n_fail++; $display("FAIL boundary_count[%0d]: got %0d expected %0d", i, rc0[i*17 +: 17], exp_c[i]); end
    end
    tick();
    n_checks++; if (flags0 !== 4'b0011) begin n_fail++; $display("FAIL boundary_flags: got %b expected 0011", flags0); end
    tick();
  endtask

  task automatic test_same_cycle();
    threshold = 17'd10;
    send_hits(10'd170, 10'd0, 10, 1'b1, 1'b1);
    x = 10'd170; y = 10'd0; pix_valid = 1'b1; pix_hit = 1'b1;
    pulse_fs();
    pix_valid = 1'b0; pix_hit = 1'b0;
    n_checks++; if (rc0[17 +: 17] !== 17'd10) begin n_fail++; $display("FAIL same_cycle_closing: got %0d expected 10", rc0[17 +: 17]); end
    tick();
    n_checks++; if (flags0 !== 4'b0010) begin n_fail++; $display("FAIL threshold_equal_flags: got %b expected 0010", flags0); end
    tick();
    threshold = 17'd0;
    pulse_fs();
    n_checks++; if (rc0[17 +: 17] !== 17'd1) begin n_fail++; $display("FAIL same_cycle_new: got %0d expected 1", rc0[17 +: 17]); end
    n_checks++; if (rc0[0 +: 17] !== 17'd0) begin n_fail++; $display("FAIL same_cycle_r0: got %0d expected 0", rc0[0 +: 17]); end
    tick();
    n_checks++; if (flags0 !== 4'b1111) begin n_fail++; $display("FAIL threshold_zero_flags: got %b expected 1111", flags0); end
    tick();
  endtask

  task automatic test_latch_restart();
    threshold = 17'd5;
    send_hits(10'd400, 10'd0, 20, 1'b1, 1'b1);
    pulse_fs();
    x = 10'd400; y = 10'd0; pix_valid = 1'b1; pix_hit = 1'b1;
    pulse_fs();
    pix_valid = 1'b0; pix_hit = 1'b0;
    n_checks++; if (fd0 !== 1'b1) begin n_fail++; $display("FAIL latch_fs_fd: got %0d expected 1", fd0); end
    n_checks++; if (rc0[34 +: 17] !== 17'd20) begin n_fail++; $display("FAIL latch_fs_count: got %0d expected 20", rc0[34 +: 17]); end
    n_checks++; if (flags0 !== 4'b0100) begin n_fail++; $display("FAIL latch_fs_flags: got %b expected 0100", flags0); end
    send_hits(10'd400, 10'd0, 6, 1'b1, 1'b1);
    pulse_fs();
    n_checks++; if (rc0[34 +: 17] !== 17'd7) begin n_fail++; $display("FAIL latch_restart_count: got %0d expected 7", rc0[34 +: 17]); end
    n_checks++; if (fd0 !== 1'b0) begin n_fail++; $display("FAIL latch_restart_fd_early: got %0d expected 0", fd0); end
    tick();
    n_checks++; if (fd0 !== 1'b1) begin n_fail++; $display("FAIL latch_restart_fd: got %0d expected 1", fd0); end
    tick();
  endtask

  task automatic test_saturate();
    threshold = 17'd100;
    send_hits(10'd200, 10'd0, 20000, 1'b1, 1'b1);
    pulse_fs();
    n_checks++; if (rc12[12 +: 12] !== 12'd4095) begin n_fail++; $display("FAIL saturate_12: got %0d expected 4095", rc12[12 +: 12]); end
    n_checks++; if (rc0[17 +: 17] !== 17'd20000) begin n_fail++; $display("FAIL count_17: got %0d expected 20000", rc0[17 +: 17]); end
    tick();
    n_checks++; if (flags12 !== 4'b0010) begin n_fail++; $display("FAIL saturate_flags: got %b expected 0010", flags12); end
    n_checks++; if (fd12 !== 1'b1) begin n_fail++; $display("FAIL saturate_fd: got %0d expected 1", fd12); end
    tick();
  endtask

  task automatic test_debounce();
    logic [8:0] above_seq;
    logic [8:0] exp_seq;
    above_seq = 9'b101000111;
`ifdef TRACKER_DEBOUNCE_EN
    exp_seq = 9'b000011100;
`else
    exp_seq = 9'b101000111;
`endif
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    pulse_fs();
    tick();
    tick();
    threshold = 17'd5;
    for (int f = 0; f < 9; f++) begin
      int n;
      logic [7:0] exp_f;
      n = above_seq[f] ? 10 : 2;
      exp_f = exp_seq[f] ? 8'h20 : 8'h00;
      send_hits(10'd410, 10'd0, n, 1'b1, 1'b1);
      pulse_fs();
      n_checks++; if (rc8[85 +: 17] !== 17'(n)) begin n_fail++; $display("FAIL debounce_count f%0d: got %0d expected %0d", f + 1, rc8[85 +: 17], n); end
      tick();
      n_checks++; if (flags8 !== exp_f) begin n_fail++; $display("FAIL debounce_flags f%0d: got %h expected %h", f + 1, flags8, exp_f); end
      n_checks++; if (fd8 !== 1'b1) begin n_fail++; $display("FAIL debounce_fd f%0d: got %0d expected 1", f + 1, fd8); end
      tick();
    end
  endtask

  task automatic test_reset_midframe();
    n_checks++; if (rc0[34 +: 17] !== 17'd10) begin n_fail++; $display("FAIL pre_reset_count: got %0d expected 10", rc0[34 +: 17]); end
    send_hits(10'd10, 10'd0, 50, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    n_checks++; if (rc0 !== 68'h0) begin n_fail++; $display("FAIL midreset_count: got %h expected 0", rc0); end
    n_checks++; if (flags0 !== 4'h0) begin n_fail++; $display("FAIL midreset_flags: got %b expected 0", flags0); end
    n_checks++; if (fd0 !== 1'b0) begin n_fail++; $display("FAIL midreset_fd: got %0d expected 0", fd0); end
    n_checks++; if (rc8 !== 136'h0) begin n_fail++; $display("FAIL midreset_count8: got %h expected 0", rc8); end
    tick();
    rst_n = 1'b1;
    send_hits(10'd10, 10'd0, 50, 1'b1, 1'b1);
    pulse_fs();
    n_checks++; if (rc0 !== 68'h0) begin n_fail++; $display("FAIL postreset_count: got %h expected 0", rc0); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (fd0 !== 1'b0) begin n_fail++; $display("FAIL postreset_fd c%0d: got %0d expected 0", k, fd0); end
      tick();
    end
    send_hits(10'd10, 10'd0, 5, 1'b1, 1'b1);
    pulse_fs();
    n_checks++; if (rc0[0 +: 17] !== 17'd5) begin n_fail++; $display("FAIL postreset_frame_count: got %0d expected 5", rc0[0 +: 17]); end
    n_checks++; if (fd0 !== 1'b0) begin n_fail++; $display("FAIL postreset_fd_early: got %0d expected 0", fd0); end
    tick();
    n_checks++; if (fd0 !== 1'b1) begin n_fail++; $display("FAIL postreset_fd: got %0d expected 1", fd0); end
    n_checks++; if (flags0 !== 4'b0001) begin n_fail++; $display("FAIL postreset_flags: got %b expected 0001", flags0); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; pix_hit = 1'b0;
    x = '0; y = '0; threshold = '0;
    test_reset();
    test_basic();
    test_boundary();
    test_same_cycle();
    test_latch_restart();
    test_saturate();
    test_debounce();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_region_tracker.md
MULTI_REGION_TRACKER -- requirements
Module: multi_region_tracker

Interface
REQ-001 Parameter NUM_REGIONS, default 4: number of equal-width vertical regions across the frame, legal range 1..16.
REQ-002 Parameter FRAME_W, default 640: active pixels per line.
REQ-003 Parameter FRAME_H, default 480: active lines per frame.
REQ-004 Parameter CNT_W, default 17: width of each per-region hit counter.
REQ-005 Parameter DEBOUNCE, default 3: consecutive frames required to change a flag; used only when TRACKER_DEBOUNCE_EN is defined.
REQ-006 CLOCK_24  in  1: sole clock; all state changes on its rising edge.
REQ-007 rst_n  in  1: reset, asynchronous, active-low.
REQ-008 frame_start  in  1: one-cycle pulse marking the start of a frame.
REQ-009 pix_valid  in  1: the current x, y and pix_hit are valid this cycle.
REQ-010 pix_hit  in  1: the current pixel matches the target colour.
REQ-011 x  in  10: pixel column.
REQ-012 y  in  10: pixel row.
REQ-013 threshold  in  CNT_W: minimum hit count for a region to be detected; sampled on the frame_start cycle.
REQ-014 region_flags  out  NUM_REGIONS: bit i is 1 when region i is detected.
REQ-015 region_count  out  NUM_REGIONS*CNT_W: last completed frame's hit counts, region 0 in the LSBs.
REQ-016 frame_done  out  1: one-cycle pulse when region_flags has been updated.

Function
REQ-017 REGION_W SHALL be FRAME_W/NUM_REGIONS (integer division), and region index SHALL be x/REGION_W.
REQ-018 Pixels with x >= NUM_REGIONS*REGION_W, y >= FRAME_H, or pix_valid=0 SHALL NOT be counted.
REQ-019 FSM states: IDLE, ACCUM, LATCH.
- IDLE->ACCUM on frame_start.
- ACCUM->LATCH on frame_start.
- LATCH->ACCUM unconditionally after one cycle.
REQ-020 On every frame_start, each hit counter SHALL be cleared; a counted hit in that same cycle SHALL load the counter with 1 for the new frame.
REQ-021 In ACCUM, on frame_start, region_count SHALL capture the counters at the next edge, and threshold SHALL be registered at the same edge.
REQ-022 In LATCH, region_flags SHALL be updated and frame_done SHALL be asserted for exactly that one cycle. Latency is frame_start -> region_count +1 cycle -> region_flags/frame_done +2 cycles.
REQ-023 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 The raw detect for region i is region_count[i] >= the registered threshold. A threshold of 0 SHALL detect every region.
REQ-025 A frame_start that arrives during LATCH SHALL still restart counting (REQ-020), and the FSM SHALL go to ACCUM.
REQ-026 The partial frame between reset release and the first frame_start SHALL be discarded.

Reset
REQ-027 While rst_n=0:
- FSM SHALL be IDLE.
- All counters, region_count, region_flags, the threshold register and debounce counters SHALL be 0.
- frame_done SHALL be 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately with no frame_done, and outputs SHALL stay 0 until the first LATCH after release.

Configuration
REQ-029 With TRACKER_DEBOUNCE_EN defined:
- region_flags[i] SHALL set only after DEBOUNCE consecutive frames with raw detect=1.
- It SHALL clear only after DEBOUNCE consecutive frames with raw detect=0.
- Each per-region run counter SHALL be clog2(DEBOUNCE+1) bits wide and SHALL reset when raw detect disagrees with the current run.
REQ-030 Without TRACKER_DEBOUNCE_EN, region_flags SHALL equal the raw detect of the last completed frame, and no debounce logic SHALL be synthesised.

Structure
REQ-031 Package tracker_pkg SHALL hold:
- FSM state typedef (IDLE/ACCUM/LATCH).
- Default constants for FRAME_W, FRAME_H, CNT_W and DEBOUNCE.
- A clog2-based width helper.
REQ-032 One sub-module, region_counter, SHALL implement a single region's saturating counter plus optional debounce, instantiated NUM_REGIONS times by generate.

Verification
REQ-033 Default parameters, threshold=100, 150 hits at x=10 in frame 1, then frame_start -> region_count[0]=150, others 0; after 2 cycles, region_flags=4'b0001 (raw) and frame_done pulses once.
REQ-034 20000 hits at x=200, CNT_W=12 -> region_count[1]=4095 (saturated).
REQ-035 Hits at x=159 and x=160, and hits at x=700 and y=480 -> counted in regions 0 and 1 only; out-of-range hits ignored.
REQ-036 NUM_REGIONS=8, TRACKER_DEBOUNCE_EN defined, region 5 above threshold for frames 1-3 then below for frames 4-6 -> flag[5] rises after the 3rd frame and falls after the 6th.
REQ-037 rst_n pulsed low mid-frame with 50 hits counted -> all outputs 0 immediately; no frame_done until the second frame_start after release.
REQ-038 Hit on the same cycle as frame_start -> excluded from the closing frame and counted as 1 in the new frame.
